// File: rtl/exec_wb_arbiter_if.sv
// exec_wb_arbiter_if
//   Bundles the execute-pipe result handshake and the writeback/state-update
//   output bus of exec_wb_arbiter.
//   master : the execute pipes / environment (drives src_*, reads ready and outputs)
//   slave  : the arbiter (reads src_*, drives src_ready, wb_*, su_*)
//   Source side : src_valid/src_ready handshake plus prd, wen, data, rob_idx,
//                 mispred, exc payload, one lane per execute pipe.
//   Output side : wb_valid/wb_wen/wb_prd/wb_data register-file writeback and
//                 su_valid/su_rob_idx/su_mispred/su_exc ROB update, one lane per port.
interface exec_wb_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_WB  = 3,
  parameter int PREG_W  = 7,
  parameter int ROB_W   = 6
);
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0][PREG_W-1:0] src_prd;
  logic [NUM_SRC-1:0]             src_wen;
  logic [NUM_SRC-1:0][31:0]       src_data;
  logic [NUM_SRC-1:0][ROB_W-1:0]  src_rob_idx;
  logic [NUM_SRC-1:0]             src_mispred;
  logic [NUM_SRC-1:0]             src_exc;

  logic [NUM_WB-1:0]              wb_valid;
  logic [NUM_WB-1:0]              wb_wen;
  logic [NUM_WB-1:0][PREG_W-1:0]  wb_prd;
  logic [NUM_WB-1:0][31:0]        wb_data;
  logic [NUM_WB-1:0]              su_valid;
  logic [NUM_WB-1:0][ROB_W-1:0]   su_rob_idx;
  logic [NUM_WB-1:0]              su_mispred;
  logic [NUM_WB-1:0]              su_exc;

  modport master (
    output src_valid, src_prd, src_wen, src_data, src_rob_idx, src_mispred, src_exc,
    input  src_ready,
    input  wb_valid, wb_wen, wb_prd, wb_data, su_valid, su_rob_idx, su_mispred, su_exc
  );

  modport slave (
    input  src_valid, src_prd, src_wen, src_data, src_rob_idx, src_mispred, src_exc,
    output src_ready,
    output wb_valid, wb_wen, wb_prd, wb_data, su_valid, su_rob_idx, su_mispred, su_exc
  );
endinterface

// File: rtl/exec_wb_arbiter.sv
// exec_wb_arbiter
//   Collects results from the execute pipes (ALU-1, ALU-2, MUL, AGU) through a
//   small per-source skid FIFO and funnels up to NUM_WB of them per cycle onto
//   the registered writeback and ROB state-update ports, round-robin.
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-low reset
//   flush : squashes every buffered and registered result
//   bus   : exec_wb_arbiter_if.slave (source handshake in, wb/su ports out);
//           its parameters must match the ones given here.
module exec_wb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_WB    = 3,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 6,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  exec_wb_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int GNT_W = $clog2(NUM_WB + 1);

  typedef struct packed {
    logic [PREG_W-1:0] prd;
    logic              wen;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob_idx;
    logic              mispred;
    logic              exc;
  } entry_t;

  entry_t           mem     [NUM_SRC][BUF_DEPTH];
  entry_t           head    [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr  [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr  [NUM_SRC];
  logic [CNT_W-1:0] count   [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr, rr_next;

  logic [NUM_SRC-1:0]            push, grant, not_empty;
  logic [NUM_WB-1:0]             port_vld;
  logic [NUM_WB-1:0][SRC_W-1:0]  port_src;
  logic [GNT_W-1:0]              n_gnt;
  logic [SRC_W-1:0]              idx;
  entry_t                        sel;

  logic [NUM_WB-1:0]             nxt_valid, nxt_wen, nxt_mispred, nxt_exc;
  logic [NUM_WB-1:0][PREG_W-1:0] nxt_prd;
  logic [NUM_WB-1:0][31:0]       nxt_data;
  logic [NUM_WB-1:0][ROB_W-1:0]  nxt_rob_idx;

  // Ready is a pure function of the registered count, so a full FIFO stays
  // not-ready even in the cycle its head is popped.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = (count[i] < CNT_W'(BUF_DEPTH)) && rst;
      push[i]          = bus.src_valid[i] && bus.src_ready[i] && !flush;
      not_empty[i]     = (count[i] != '0);
      head[i]          = mem[i][rd_ptr[i]];
    end
  end

  // Round-robin scan starting at rr_ptr; the first grant lands on port 0.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path through the loop can leave it unassigned and infer a latch.
    grant    = '0;
    port_vld = '0;
    port_src = '0;
    rr_next  = rr_ptr;
    n_gnt    = '0;
    idx      = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = SRC_W'((int'(rr_ptr) + j) % NUM_SRC);
      if (not_empty[idx] && (n_gnt < GNT_W'(NUM_WB))) begin
        grant[idx]      = 1'b1;
        port_vld[n_gnt] = 1'b1;
        port_src[n_gnt] = idx;
        rr_next         = SRC_W'((int'(idx) + 1) % NUM_SRC);
        n_gnt           = n_gnt + GNT_W'(1);
      end
    end
  end

  // Unused ports and flushed cycles load all-zero payloads.
  always_comb begin
    nxt_valid   = '0;
    nxt_wen     = '0;
    nxt_prd     = '0;
    nxt_data    = '0;
    nxt_rob_idx = '0;
    nxt_mispred = '0;
    nxt_exc     = '0;
    sel         = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (port_vld[k] && !flush) begin
        sel            = head[port_src[k]];
        nxt_valid[k]   = 1'b1;
        // Writes to p0 are suppressed; the ROB update still fires.
        nxt_wen[k]     = sel.wen && (sel.prd != '0);
        nxt_prd[k]     = sel.prd;
        nxt_data[k]    = sel.data;
        nxt_rob_idx[k] = sel.rob_idx;
        nxt_mispred[k] = sel.mispred;
        nxt_exc[k]     = sel.exc;
      end
    end
  end

  // FIFO storage carries no reset: validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        mem[i][wr_ptr[i]] <= '{prd:     bus.src_prd[i],
                               wen:     bus.src_wen[i],
                               data:    bus.src_data[i],
                               rob_idx: bus.src_rob_idx[i],
                               mispred: bus.src_mispred[i],
                               exc:     bus.src_exc[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wb_valid   <= '0;
      bus.wb_wen     <= '0;
      bus.wb_prd     <= '0;
      bus.wb_data    <= '0;
      bus.su_valid   <= '0;
      bus.su_rob_idx <= '0;
      bus.su_mispred <= '0;
      bus.su_exc     <= '0;
    end else begin
      bus.wb_valid   <= nxt_valid;
      bus.wb_wen     <= nxt_wen;
      bus.wb_prd     <= nxt_prd;
      bus.wb_data    <= nxt_data;
      bus.su_valid   <= nxt_valid;
      bus.su_rob_idx <= nxt_rob_idx;
      bus.su_mispred <= nxt_mispred;
      bus.su_exc     <= nxt_exc;
    end
  end
endmodule

// File: tb/tb_exec_wb_arbiter.sv
// tb_exec_wb_arbiter
//   Self-checking bench for exec_wb_arbiter. A queue-per-source reference model
//   predicts the registered wb/su outputs and src_ready every cycle; directed
//   steps cover the single-result latency, p0/branch handling, saturation,
//   flush and asynchronous reset, followed by randomized traffic.
module tb_exec_wb_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int NUM_WB    = 3;
  localparam int PREG_W    = 7;
  localparam int ROB_W     = 6;
  localparam int BUF_DEPTH = 2;

  typedef struct packed {
    logic [PREG_W-1:0] prd;
    logic              wen;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob;
    logic              mis;
    logic              exc;
  } ent_t;

  logic clk;
  logic rst;
  logic flush;

  exec_wb_arbiter_if #(.NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

  exec_wb_arbiter #(
    .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .PREG_W(PREG_W), .ROB_W(ROB_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per source and the round-robin start point.
  ent_t q [NUM_SRC][$];
  int   rr_m = 0;

  logic [NUM_WB-1:0]             e_valid, e_wen, e_mis, e_exc;
  logic [NUM_WB-1:0][PREG_W-1:0] e_prd;
  logic [NUM_WB-1:0][31:0]       e_data;
  logic [NUM_WB-1:0][ROB_W-1:0]  e_rob;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NUM_SRC; s++) q[s].delete();
    rr_m    = 0;
    e_valid = '0; e_wen = '0; e_mis = '0; e_exc = '0;
    e_prd   = '0; e_data = '0; e_rob = '0;
  endtask

  function automatic logic [NUM_SRC-1:0] model_ready();
    logic [NUM_SRC-1:0] r;
    for (int s = 0; s < NUM_SRC; s++) r[s] = (q[s].size() < BUF_DEPTH) && rst;
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs now on the bus.
  task automatic model_step();
    logic [NUM_SRC-1:0] rdy;
    ent_t e;
    int   n;
    int   last;
    int   s;
    rdy = model_ready();
    if (flush) begin
      model_clear();
      return;
    end
    e_valid = '0; e_wen = '0; e_mis = '0; e_exc = '0;
    e_prd   = '0; e_data = '0; e_rob = '0;
    n = 0;
    last = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = (rr_m + j) % NUM_SRC;
      if (n < NUM_WB && q[s].size() > 0) begin
        e = q[s].pop_front();
        e_valid[n] = 1'b1;
        e_wen[n]   = e.wen && (e.prd != 0);
        e_prd[n]   = e.prd;
        e_data[n]  = e.data;
        e_rob[n]   = e.rob;
        e_mis[n]   = e.mis;
        e_exc[n]   = e.exc;
        last = s;
        n++;
      end
    end
    if (n > 0) rr_m = (last + 1) % NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_valid[i] && rdy[i]) begin
        q[i].push_back('{prd: bus.src_prd[i], wen: bus.src_wen[i], data: bus.src_data[i],
                         rob: bus.src_rob_idx[i], mis: bus.src_mispred[i], exc: bus.src_exc[i]});
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_wb_valid"},   128'(bus.wb_valid),   128'(e_valid));
    check({ph, "_su_valid"},   128'(bus.su_valid),   128'(e_valid));
    check({ph, "_wb_wen"},     128'(bus.wb_wen),     128'(e_wen));
    check({ph, "_wb_prd"},     128'(bus.wb_prd),     128'(e_prd));
    check({ph, "_wb_data"},    128'(bus.wb_data),    128'(e_data));
    check({ph, "_su_rob_idx"}, 128'(bus.su_rob_idx), 128'(e_rob));
    check({ph, "_su_mispred"}, 128'(bus.su_mispred), 128'(e_mis));
    check({ph, "_su_exc"},     128'(bus.su_exc),     128'(e_exc));
    check({ph, "_src_ready"},  128'(bus.src_ready),  128'(model_ready()));
  endtask

  task automatic set_payload(input int s, input logic [PREG_W-1:0] prd, input logic wen,
                             input logic [31:0] data, input logic [ROB_W-1:0] rob,
                             input logic mis, input logic exc);
    bus.src_prd[s]     = prd;
    bus.src_wen[s]     = wen;
    bus.src_data[s]    = data;
    bus.src_rob_idx[s] = rob;
    bus.src_mispred[s] = mis;
    bus.src_exc[s]     = exc;
  endtask

  task automatic rand_payloads();
    for (int s = 0; s < NUM_SRC; s++) begin
      set_payload(s, PREG_W'($urandom), 1'($urandom), $urandom, ROB_W'($urandom),
                  1'($urandom), 1'($urandom));
    end
  endtask

  // Called at a falling edge: apply inputs, step the model over the next
  // rising edge, then check at the following falling edge.
  task automatic drive_cycle(input string ph, input logic [NUM_SRC-1:0] vld, input logic fl);
    bus.src_valid = vld;
    flush         = fl;
    model_step();
    @(negedge clk);
    check_outputs(ph);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.src_valid = '0;
    for (int s = 0; s < NUM_SRC; s++) set_payload(s, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    model_clear();

    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU-1 result: visible two edges after the handshake, on port 0.
    set_payload(0, 7'd5, 1'b1, 32'hDEAD_BEEF, 6'd3, 1'b0, 1'b0);
    drive_cycle("single_c1", 4'b0001, 1'b0);
    check("single_c1_idle", 128'(bus.wb_valid), 128'(3'b000));
    drive_cycle("single_c2", 4'b0000, 1'b0);
    check("single_valid", 128'(bus.wb_valid),      128'(3'b001));
    check("single_prd",   128'(bus.wb_prd[0]),     128'(7'd5));
    check("single_data",  128'(bus.wb_data[0]),    128'(32'hDEAD_BEEF));
    check("single_rob",   128'(bus.su_rob_idx[0]), 128'(6'd3));

    // Write to p0 from ALU-1 and a mispredicted branch from ALU-2 together.
    // rr_ptr is 1 after the previous grant of source 0, so ALU-2 takes port 0.
    set_payload(0, 7'd0,  1'b1, 32'h1234_5678, 6'd10, 1'b0, 1'b0);
    set_payload(1, 7'd33, 1'b0, 32'h0BAD_F00D, 6'd11, 1'b1, 1'b0);
    drive_cycle("p0br_c1", 4'b0011, 1'b0);
    drive_cycle("p0br_c2", 4'b0000, 1'b0);
    check("p0br_su_valid", 128'(bus.su_valid),      128'(3'b011));
    check("p0br_wb_wen",   128'(bus.wb_wen),        128'(3'b000));
    check("p0br_mispred",  128'(bus.su_mispred),    128'(3'b001));
    check("p0br_rob0",     128'(bus.su_rob_idx[0]), 128'(6'd11));
    check("p0br_rob1",     128'(bus.su_rob_idx[1]), 128'(6'd10));

    // All four sources valid every cycle: FIFOs fill and ready throttles.
    for (int c = 0; c < 12; c++) begin
      rand_payloads();
      drive_cycle("sat", 4'b1111, 1'b0);
    end
    check("sat_three_per_cycle", 128'(bus.wb_valid), 128'(3'b111));

    // Flush with full FIFOs and every source still presenting a result.
    rand_payloads();
    drive_cycle("flush", 4'b1111, 1'b1);
    check("flush_valid", 128'(bus.wb_valid),  128'(3'b000));
    check("flush_ready", 128'(bus.src_ready), 128'(4'b1111));
    drive_cycle("post_flush1", 4'b0000, 1'b0);
    drive_cycle("post_flush2", 4'b0000, 1'b0);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 5; c++) begin
      rand_payloads();
      drive_cycle("pre_rst", 4'b1111, 1'b0);
    end
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    bus.src_valid = '0;
    check_outputs("in_rst");
    rst = 1'b1;
    set_payload(2, 7'd77, 1'b1, 32'hCAFE_0001, 6'd42, 1'b0, 1'b1);
    drive_cycle("post_rst_c1", 4'b0100, 1'b0);
    drive_cycle("post_rst_c2", 4'b0000, 1'b0);
    check("post_rst_valid", 128'(bus.wb_valid),   128'(3'b001));
    check("post_rst_data",  128'(bus.wb_data[0]), 128'(32'hCAFE_0001));
    check("post_rst_exc",   128'(bus.su_exc),     128'(3'b001));

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      rand_payloads();
      drive_cycle("rand", NUM_SRC'($urandom), ($urandom_range(0, 39) == 0));
    end
    bus.src_valid = '0;
    for (int c = 0; c < 4; c++) drive_cycle("drain", 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
